input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 15 +
 rtl/input_conditioner_if.sv | 12 +
 rtl/input_conditioner_channel.sv | 104 ++++++++++
 rtl/input_conditioner.sv | 32 +++
 tb/tb_input_conditioner.sv | 125 ++++++++++++
 5 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared types and default parameters for the key/switch input conditioner.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } debounce_state_e;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_DEBOUNCE   = 4;
    localparam bit DEF_ACTIVE_LOW = 1'b1;

endpackage

// File: rtl/input_conditioner_if.sv
// Raw inputs in, debounced levels and edge strobes out.
interface input_conditioner_if #(
    parameter int WIDTH = input_conditioner_pkg::DEF_WIDTH
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;

    modport master (output raw_in, input level_out, rise_pulse, fall_pulse);
    modport slave  (input raw_in, output level_out, rise_pulse, fall_pulse);
endinterface

// File: rtl/input_conditioner_channel.sv
// One channel: polarity fix, 2-flop synchronizer, debounce FSM + counter, edge strobes.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE   = DEF_DEBOUNCE,
    parameter bit ACTIVE_LOW = DEF_ACTIVE_LOW
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    logic              pol_in;
    logic [1:0]        sync_q;
    logic              synced;
    debounce_state_e   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              level_q, level_d;
    logic              rise_q, fall_q;

    assign pol_in  = ACTIVE_LOW ? ~raw_i : raw_i;
    assign synced  = sync_q[1];
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            STABLE_LO: if (synced) begin
                if (DEBOUNCE == 1) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    state_d = PEND_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            PEND_HI: begin
                if (!synced) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            STABLE_HI: if (!synced) begin
                if (DEBOUNCE == 1) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    state_d = PEND_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            PEND_LO: begin
                if (synced) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
        // Level follows the state being entered, so it updates on the accepting edge.
        level_d = (state_d == STABLE_HI) || (state_d == PEND_LO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pol_in};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/input_conditioner.sv
// Top: WIDTH independent debounce channels behind one interface port.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEBOUNCE   = DEF_DEBOUNCE,
    parameter bit ACTIVE_LOW = DEF_ACTIVE_LOW
) (
    input  logic                clk,
    input  logic                reset,
    input_conditioner_if.slave  io
);
    logic [WIDTH-1:0] level, rise, fall;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE   (DEBOUNCE),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .raw_i   (io.raw_in[g]),
            .level_o (level[g]),
            .rise_o  (rise[g]),
            .fall_o  (fall[g])
        );
    end

    assign io.level_out  = level;
    assign io.rise_pulse = rise;
    assign io.fall_pulse = fall;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed per-cycle vectors for the 4-channel, DEBOUNCE=4, active-low conditioner.
module tb_input_conditioner;
    logic clk = 1'b0;
    logic reset;

    input_conditioner_if #(.WIDTH(4)) io ();

    input_conditioner #(
        .WIDTH      (4),
        .DEBOUNCE   (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] raw;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t vecs[128];
    int   nvec = 0;
    int   cmp  = 0;
    int   mism = 0;

    task automatic add(input int n, input logic r, input logic [3:0] raw,
                       input logic [3:0] lvl, input logic [3:0] rise, input logic [3:0] fall);
        for (int i = 0; i < n; i++) begin
            vecs[nvec] = '{rst: r, raw: raw, lvl: lvl, rise: rise, fall: fall};
            nvec++;
        end
    endtask

    task automatic check4(input string name, input int row, input logic [3:0] got, input logic [3:0] want);
        cmp++;
        if (got !== want) begin
            mism++;
            $display("FAIL %s row %0d: got %b want %b", name, row, got, want);
        end
    endtask

    initial begin
        int  n;
        bit  seen;

        // Reset with all keys released, then idle.
        add(2, 1, 4'hF, 4'h0, 4'h0, 4'h0);
        add(3, 0, 4'hF, 4'h0, 4'h0, 4'h0);
        // Press ch0: level at 6th edge, one rise strobe.
        add(5, 0, 4'hE, 4'h0, 4'h0, 4'h0);
        add(1, 0, 4'hE, 4'h1, 4'h1, 4'h0);
        add(2, 0, 4'hE, 4'h1, 4'h0, 4'h0);
        // Release ch0: fall strobe only.
        add(5, 0, 4'hF, 4'h1, 4'h0, 4'h0);
        add(1, 0, 4'hF, 4'h0, 4'h0, 4'h1);
        add(2, 0, 4'hF, 4'h0, 4'h0, 4'h0);
        // Bounce ch1 every 2 cycles for 12 cycles, then hold pressed.
        for (int k = 0; k < 6; k++)
            add(2, 0, (k % 2 == 0) ? 4'hD : 4'hF, 4'h0, 4'h0, 4'h0);
        add(5, 0, 4'hD, 4'h0, 4'h0, 4'h0);
        add(1, 0, 4'hD, 4'h2, 4'h2, 4'h0);
        add(2, 0, 4'hD, 4'h2, 4'h0, 4'h0);
        // Press ch2, reset mid-pending; ch1 and ch2 both re-qualify after release.
        add(4, 0, 4'h9, 4'h2, 4'h0, 4'h0);
        add(1, 1, 4'h9, 4'h0, 4'h0, 4'h0);
        add(5, 0, 4'h9, 4'h0, 4'h0, 4'h0);
        add(1, 0, 4'h9, 4'h6, 4'h6, 4'h0);
        add(2, 0, 4'h9, 4'h6, 4'h0, 4'h0);
        // Release all, then press ch3:2 together.
        add(5, 0, 4'hF, 4'h6, 4'h0, 4'h0);
        add(1, 0, 4'hF, 4'h0, 4'h0, 4'h6);
        add(2, 0, 4'hF, 4'h0, 4'h0, 4'h0);
        add(5, 0, 4'h3, 4'h0, 4'h0, 4'h0);
        add(1, 0, 4'h3, 4'hC, 4'hC, 4'h0);
        add(2, 0, 4'h3, 4'hC, 4'h0, 4'h0);
        // 3-sample glitch on ch0 is rejected.
        add(3, 0, 4'h2, 4'hC, 4'h0, 4'h0);
        add(6, 0, 4'h3, 4'hC, 4'h0, 4'h0);

        for (int i = 0; i < nvec; i++) begin
            reset     = vecs[i].rst;
            io.raw_in = vecs[i].raw;
            @(posedge clk);
            @(negedge clk);
            check4("level", i, io.level_out,  vecs[i].lvl);
            check4("rise",  i, io.rise_pulse, vecs[i].rise);
            check4("fall",  i, io.fall_pulse, vecs[i].fall);
        end

        // Bounded wait for ch0 press latency; rise and fall never coincide.
        io.raw_in = 4'h2;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            check4("no_rise_and_fall", n, io.rise_pulse & io.fall_pulse, 4'h0);
            if (io.level_out[0]) seen = 1'b1;
        end
        cmp++;
        if (!seen) begin
            mism++;
            $display("FAIL latency_timeout: level_out[0] still 0 after %0d edges, want 1 at edge 6", n);
        end else if (n != 6) begin
            mism++;
            $display("FAIL latency: level_out[0] rose at edge %0d, want 6", n);
        end
        check4("latency_rise", n, io.rise_pulse, 4'h1);
        @(posedge clk);
        @(negedge clk);
        check4("latency_rise_drop", n + 1, io.rise_pulse, 4'h0);
        check4("latency_level_hold", n + 1, io.level_out, 4'hD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end
endmodule
